// File: rtl/lab1_pkg.sv
// Shared constants and state encoding for the Lab1 truth-table scanner.
package lab1_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int N_VEC = 16;
  localparam int VEC_W = 4;
  localparam int CNT_W = 8;

endpackage

// File: rtl/lab1_hold_timer.sv
// Hold counter: counts clocks while enabled and ticks on the last clock of each hold window.
module lab1_hold_timer
  import lab1_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lab1_truth_table_scanner.sv
// Clocked sweep of the Lab1 function inputs with per-vector capture of F into a 16-bit table.
// Optional table compare against EXP_TABLE is built when LAB1_SCAN_COMPARE_EN is defined.
module lab1_truth_table_scanner
  import lab1_pkg::*;
#(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXP_TABLE   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table
`ifdef LAB1_SCAN_COMPARE_EN
  ,
  output logic        pass,
  output logic        fail
`endif
);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_VEC-1:0]   tt_q, tt_d;
  logic               timer_clr;
  logic               timer_en;
  logic               tick;
  logic               accept;
  logic               last;

  lab1_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tt_d      = tt_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          accept    = 1'b1;
          vec_d     = '0;
          tt_d      = '0;
          state_d   = ST_SWEEP;
          busy_d    = 1'b1;
          timer_clr = 1'b1;
        end
      end
      ST_SWEEP: begin
        timer_en = 1'b1;
        if (tick) begin
          tt_d[vec_q] = F;
          // The sweep ends at the last vector rather than wrapping.
          if (vec_q == VEC_W'(N_VEC - 1)) begin
            last    = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
    end
  end

  assign {A, B, C, D} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth_table  = tt_q;

`ifdef LAB1_SCAN_COMPARE_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  // Compare uses tt_d so the bit sampled at the final edge is included.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (accept) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (last) begin
      pass_d = (tt_d == EXP_TABLE);
      fail_d = (tt_d != EXP_TABLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`else
  logic unused_exp_table;
  assign unused_exp_table = ^{EXP_TABLE, accept, last};
`endif

endmodule

// File: tb/tb_lab1_truth_table_scanner.sv
// Directed bench for lab1_truth_table_scanner: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
module tb_lab1_truth_table_scanner;

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic        f0, f1;
  logic        a0, b0, c0, d0;
  logic        a1, b1, c1, d1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [15:0] tt0, tt1;
`ifdef LAB1_SCAN_COMPARE_EN
  logic        pass0, fail0, pass1, fail1;
`endif

  int fmode0;
  int fmode1;
  int errors;
  int checks;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  lab1_truth_table_scanner #(.HOLD_CYCLES(4), .EXP_TABLE(16'h55AA)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .F(f0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .busy(busy0), .done(done0), .truth_table(tt0)
`ifdef LAB1_SCAN_COMPARE_EN
    , .pass(pass0), .fail(fail0)
`endif
  );

  lab1_truth_table_scanner #(.HOLD_CYCLES(1), .EXP_TABLE(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .F(f1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .truth_table(tt1)
`ifdef LAB1_SCAN_COMPARE_EN
    , .pass(pass1), .fail(fail1)
`endif
  );

  // Function under test, selected per instance.
  function automatic logic lab1_f(input int mode, input logic [3:0] v);
    case (mode)
      0: return v[3] ^ v[0];
      1: return 1'b1;
      2: return 1'b0;
      3: return (v[3] ^ v[0]) ^ (v == 4'd5);
      default: return 1'b0;
    endcase
  endfunction

  always_comb f0 = lab1_f(fmode0, {a0, b0, c0, d0});
  always_comb f1 = lab1_f(fmode1, {a1, b1, c1, d1});

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on dut0 (HOLD_CYCLES=4); optional ignored starts at cycles ign_a/ign_b.
  task automatic sweep0(input int ign_a, input int ign_b, input logic [15:0] exp_tt);
    int dones;
    dones = 0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int c = 0; c <= 66; c++) begin
      if (c == 0 || c == 3 || c == 4 || c == 31 || c == 63 || c == 64 || c == 66) begin
        check("s0_vec", {28'b0, a0, b0, c0, d0}, (c < 64) ? c / 4 : 0);
        check("s0_busy", {31'b0, busy0}, (c < 64) ? 1 : 0);
        check("s0_done", {31'b0, done0}, (c == 64) ? 1 : 0);
      end
      if (c == 64 || c == 66) check("s0_tt", {16'b0, tt0}, {16'b0, exp_tt});
      if (done0) dones++;
      start0 = (c == ign_a || c == ign_b);
      @(negedge clk);
    end
    check("s0_done_count", dones, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    errors = 0;
    checks = 0;
    fmode0 = 0;
    fmode1 = 1;
    start0 = 1'b0;
    start1 = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vec", {28'b0, a0, b0, c0, d0}, 0);
    check("rst_busy", {31'b0, busy0}, 0);
    check("rst_done", {31'b0, done0}, 0);
    check("rst_tt", {16'b0, tt0}, 0);
`ifdef LAB1_SCAN_COMPARE_EN
    check("rst_pass", {31'b0, pass0}, 0);
    check("rst_fail", {31'b0, fail0}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // F = A^D, HOLD_CYCLES=4
    sweep0(-1, -1, 16'h55AA);
`ifdef LAB1_SCAN_COMPARE_EN
    check("cmp_pass", {31'b0, pass0}, 1);
    check("cmp_fail", {31'b0, fail0}, 0);
`endif

    // F tied to 1, HOLD_CYCLES=1
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("h1_vec0", {28'b0, a1, b1, c1, d1}, 0);
    repeat (5) @(negedge clk);
    check("h1_vec5", {28'b0, a1, b1, c1, d1}, 5);
    check("h1_partial_tt", {16'b0, tt1}, 32'h001F);
    repeat (11) @(negedge clk);
    check("h1_done", {31'b0, done1}, 1);
    check("h1_tt_ones", {16'b0, tt1}, 32'hFFFF);
    // start during the done cycle is accepted
    fmode1 = 2;
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check("h1_restart_busy", {31'b0, busy1}, 1);
    check("h1_restart_tt", {16'b0, tt1}, 0);
    check("h1_restart_done", {31'b0, done1}, 0);
    repeat (16) @(negedge clk);
    check("h1_done2", {31'b0, done1}, 1);
    check("h1_tt_zero", {16'b0, tt1}, 0);
    @(negedge clk);
    check("h1_done2_low", {31'b0, done1}, 0);

    // start pulses at cycles 10 and 30 are ignored
    sweep0(10, 30, 16'h55AA);

    // asynchronous reset mid-sweep
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_vec", {28'b0, a0, b0, c0, d0}, 5);
    check("pre_rst_tt", {16'b0, tt0}, 32'h000A);
    #2 rst = 1'b1;
    #1;
    check("arst_vec", {28'b0, a0, b0, c0, d0}, 0);
    check("arst_busy", {31'b0, busy0}, 0);
    check("arst_done", {31'b0, done0}, 0);
    check("arst_tt", {16'b0, tt0}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done0) check("arst_no_done", {31'b0, done0}, 0);
    end
    sweep0(-1, -1, 16'h55AA);

    // F inverted at vec=5
    fmode0 = 3;
    sweep0(-1, -1, 16'h558A);
`ifdef LAB1_SCAN_COMPARE_EN
    check("cmp2_pass", {31'b0, pass0}, 0);
    check("cmp2_fail", {31'b0, fail0}, 1);
`endif
    fmode0 = 0;

    // start held high through done: back-to-back sweeps
    @(negedge clk) start0 = 1'b1;
    @(negedge clk);
`ifdef LAB1_SCAN_COMPARE_EN
    check("cmp_cleared", {30'b0, pass0, fail0}, 0);
`endif
    repeat (64) @(negedge clk);
    check("b2b_done", {31'b0, done0}, 1);
    check("b2b_vec_in_done", {28'b0, a0, b0, c0, d0}, 0);
    check("b2b_tt", {16'b0, tt0}, 32'h55AA);
    @(negedge clk) start0 = 1'b0;
    check("b2b_busy2", {31'b0, busy0}, 1);
    check("b2b_tt_clear", {16'b0, tt0}, 0);
    check("b2b_done_low", {31'b0, done0}, 0);
    repeat (63) @(negedge clk);
    check("b2b_done2_early", {31'b0, done0}, 0);
    @(negedge clk);
    check("b2b_done2", {31'b0, done0}, 1);
    check("b2b_tt2", {16'b0, tt0}, 32'h55AA);
    @(negedge clk);
    check("b2b_idle", {30'b0, busy0, done0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
